// File: rtl/bcd_7seg_scan.sv
// 3-digit multiplexed 7-segment driver for a BCD word that
// settles over several cycles; captures only stable values.
module bcd_7seg_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int STABLE_CYC     = 12,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bdc,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] disp_val
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int PW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_LD   = CW'(STABLE_CYC - 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);

  localparam logic [6:0] ZERO_AL = 7'h40;
  localparam logic [6:0] SEG_RST =
    SEG_ACTIVE_LOW ? ZERO_AL : ~ZERO_AL;

  typedef enum logic [1:0] {
    DIG_U = 2'd0,
    DIG_T = 2'd1,
    DIG_H = 2'd2
  } dsel_e;

  logic [11:0]   smp_q, smp_d;
  logic [CW-1:0] stab_cnt_q, stab_cnt_d;
  logic [11:0]   disp_val_q, disp_val_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  dsel_e         dsel_q, dsel_d;
  logic [2:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [3:0] nib;
  logic       blank;
  logic [6:0] code;

  // Stability filter: reload disp only after a run of equal samples
  always_comb begin
    smp_d      = bdc;
    stab_cnt_d = stab_cnt_q;
    disp_val_d = disp_val_q;
    if (bdc != smp_q) begin
      stab_cnt_d = '0;
    end else begin
      if (stab_cnt_q < CNT_MAX)
        stab_cnt_d = stab_cnt_q + CW'(1);
      if (stab_cnt_q == CNT_LD)
        disp_val_d = smp_q;
    end
  end

  // Scan timer and digit select, units -> tens -> hundreds
  always_comb begin
    pcnt_d = pcnt_q + PW'(1);
    dsel_d = dsel_q;
    if (pcnt_q == PCNT_MAX) begin
      pcnt_d = '0;
      unique case (dsel_q)
        DIG_U:   dsel_d = DIG_T;
        DIG_T:   dsel_d = DIG_H;
        DIG_H:   dsel_d = DIG_U;
        default: dsel_d = DIG_U;
      endcase
    end
  end

  // Digit pick, leading-zero blanking and segment decode
  always_comb begin
    nib   = disp_val_q[3:0];
    blank = 1'b0;
    unique case (dsel_q)
      DIG_U: nib = disp_val_q[3:0];
      DIG_T: begin
        nib   = disp_val_q[7:4];
        blank = BLANK_LZ &&
                disp_val_q[11:8] == 4'h0 &&
                disp_val_q[7:4] == 4'h0;
      end
      DIG_H: begin
        nib   = disp_val_q[11:8];
        blank = BLANK_LZ &&
                disp_val_q[11:8] == 4'h0;
      end
      default: nib = disp_val_q[3:0];
    endcase
    unique case (nib)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h3F;
    endcase
    if (blank)
      code = 7'h7F;
    seg_d = SEG_ACTIVE_LOW ? code : ~code;
    an_d  = ~(3'b001 << dsel_q);
  end

  // State register; everything held while rst is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q      <= '0;
      stab_cnt_q <= '0;
      disp_val_q <= '0;
      pcnt_q     <= '0;
      dsel_q     <= DIG_U;
      an_q       <= 3'b110;
      seg_q      <= SEG_RST;
    end else begin
      smp_q      <= smp_d;
      stab_cnt_q <= stab_cnt_d;
      disp_val_q <= disp_val_d;
      pcnt_q     <= pcnt_d;
      dsel_q     <= dsel_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign disp_val = disp_val_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Randomised self-checking bench for bcd_7seg_scan using a
// run-length / cycle-count reference model.
module tb_bcd_7seg_scan;

  localparam int SD = 4;
  localparam int SC = 12;

  logic        clk;
  logic        rst;
  logic [11:0] bdc;
  logic [6:0]  seg_a, seg_b, seg_c;
  logic [2:0]  an_a, an_b, an_c;
  logic [11:0] disp_a, disp_b, disp_c;

  int n_cmp;
  int n_bad;

  bcd_7seg_scan #(
    .SCAN_DIV(SD), .STABLE_CYC(SC),
    .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .bdc(bdc),
    .seg(seg_a), .an(an_a), .disp_val(disp_a)
  );

  bcd_7seg_scan #(
    .SCAN_DIV(SD), .STABLE_CYC(SC),
    .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .bdc(bdc),
    .seg(seg_b), .an(an_b), .disp_val(disp_b)
  );

  bcd_7seg_scan #(
    .SCAN_DIV(SD), .STABLE_CYC(SC),
    .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .bdc(bdc),
    .seg(seg_c), .an(an_c), .disp_val(disp_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [11:0] m_prev;
  int          m_run;
  logic [11:0] m_disp;
  logic [11:0] m_shown;
  int          m_dig;
  int          m_n;
  logic [2:0]  m_an;

  // Filter: a value seen on SC+1 consecutive edges is shown.
  // Display: edge n (from 1) shows digit ((n-1)/SD)%3 of the
  // word that was captured before that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev  <= 12'h000;
      m_run   <= 1;
      m_disp  <= 12'h000;
      m_shown <= 12'h000;
      m_dig   <= 0;
      m_n     <= 0;
      m_an    <= 3'b110;
    end else begin
      m_dig   <= (m_n / SD) % 3;
      m_an    <= ~(3'b001 << ((m_n / SD) % 3));
      m_shown <= m_disp;
      m_n     <= m_n + 1;
      if (bdc == m_prev) begin
        m_run <= (m_run < 1000) ? m_run + 1 : m_run;
        if (m_run + 1 >= SC + 1)
          m_disp <= bdc;
      end else begin
        m_prev <= bdc;
        m_run  <= 1;
      end
    end
  end

  function automatic logic [6:0] exp_seg(
    input logic [11:0] w, input int dig,
    input bit blz, input bit al);
    logic [3:0] nb;
    logic [6:0] c;
    bit         blk;
    nb  = 4'((w >> (4 * dig)) & 12'hF);
    blk = blz && ((dig == 2 && w[11:8] == 0) ||
          (dig == 1 && w[11:4] == 0));
    case (nb)
      0: c = 7'h40; 1: c = 7'h79; 2: c = 7'h24;
      3: c = 7'h30; 4: c = 7'h19; 5: c = 7'h12;
      6: c = 7'h02; 7: c = 7'h78; 8: c = 7'h00;
      9: c = 7'h10;
      default: c = 7'h3F;
    endcase
    if (blk) c = 7'h7F;
    return al ? c : ~c;
  endfunction

  task automatic test_reset();
    bdc = 12'($urandom_range(0, 12'h254));
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (an_a !== 3'b110 || seg_a !== 7'h40 ||
        disp_a !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_a an=%b seg=%h disp=%h want 110/40/000",
               an_a, seg_a, disp_a);
    end
    n_cmp++;
    if (seg_c !== 7'h3F || an_c !== 3'b110) begin
      n_bad++;
      $display("FAIL reset_c seg=%h an=%b want 3f/110",
               seg_c, an_c);
    end
    #4 rst = 1'b1;
    #3 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (an_a !== 3'b110 || disp_a !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_units an=%b disp=%h want 110/000",
               an_a, disp_a);
    end
    repeat (10) begin
      @(negedge clk);
      n_cmp++;
      if (an_a !== m_an || disp_a !== m_disp) begin
        n_bad++;
        $display("FAIL reset_scan an=%b disp=%h want %b/%h",
                 an_a, disp_a, m_an, m_disp);
      end
    end
  endtask

  task automatic test_hold_255();
    bdc = 12'h000;
    repeat (2) @(negedge clk);
    bdc = 12'h255;
    for (int k = 1; k <= SC + 1; k++) begin
      @(negedge clk);
      if (k == SC) begin
        n_cmp++;
        if (disp_a === 12'h255) begin
          n_bad++;
          $display("FAIL hold_early disp=%h at edge %0d want not 255",
                   disp_a, k);
        end
      end
    end
    n_cmp++;
    if (disp_a !== 12'h255) begin
      n_bad++;
      $display("FAIL hold_edge13 disp=%h want 255", disp_a);
    end
    repeat (30) begin
      @(negedge clk);
      n_cmp++;
      if (an_a !== m_an ||
          seg_a !== exp_seg(m_shown, m_dig, 1, 1)) begin
        n_bad++;
        $display("FAIL hold_scan an=%b seg=%h want %b/%h",
                 an_a, seg_a, m_an,
                 exp_seg(m_shown, m_dig, 1, 1));
      end
    end
  endtask

  task automatic test_steps();
    logic [11:0] seq [4];
    seq = '{12'h001, 12'h013, 12'h064, 12'h128};
    for (int s = 0; s < 4; s++) begin
      bdc = seq[s];
      repeat (s == 3 ? 16 : 5) begin
        @(negedge clk);
        n_cmp++;
        if (disp_a === 12'h001 || disp_a === 12'h013 ||
            disp_a === 12'h064 || disp_a !== m_disp) begin
          n_bad++;
          $display("FAIL steps disp=%h want %h", disp_a, m_disp);
        end
      end
    end
    n_cmp++;
    if (disp_a !== 12'h128) begin
      n_bad++;
      $display("FAIL steps_final disp=%h want 128", disp_a);
    end
  endtask

  task automatic test_blanking();
    logic [11:0] v [3];
    v = '{12'h007, 12'h050, 12'h0A3};
    for (int s = 0; s < 3; s++) begin
      bdc = v[s];
      repeat (SC + 2 + 3 * SD) begin
        @(negedge clk);
        n_cmp++;
        if (seg_a !== exp_seg(m_shown, m_dig, 1, 1) ||
            seg_b !== exp_seg(m_shown, m_dig, 0, 1) ||
            seg_c !== exp_seg(m_shown, m_dig, 1, 0)) begin
          n_bad++;
          $display("FAIL blank a=%h b=%h c=%h want %h %h %h",
                   seg_a, seg_b, seg_c,
                   exp_seg(m_shown, m_dig, 1, 1),
                   exp_seg(m_shown, m_dig, 0, 1),
                   exp_seg(m_shown, m_dig, 1, 0));
        end
      end
    end
  endtask

  task automatic test_period();
    int  cyc;
    bit  found;
    logic [2:0] prev;
    bdc = 12'h180;
    repeat (SC + 3) @(negedge clk);
    for (int r = 0; r < 3 * SD; r++) begin
      @(negedge clk);
      n_cmp++;
      if ((an_c == 3'b110 && seg_c !== 7'h3F) ||
          (an_c == 3'b101 && seg_c !== 7'h7F) ||
          (an_c == 3'b011 && seg_c !== 7'h06) ||
          an_c !== m_an) begin
        n_bad++;
        $display("FAIL act_high an=%b seg=%h want an %b",
                 an_c, seg_c, m_an);
      end
    end
    for (int rep = 0; rep < 2; rep++) begin
      found = 0;
      cyc   = 0;
      prev  = an_c;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        cyc++;
        if (an_c == 3'b110 && prev != 3'b110) found = 1;
        prev = an_c;
      end
      if (rep == 1) begin
        n_cmp++;
        if (!found || cyc != 3 * SD) begin
          n_bad++;
          $display("FAIL an_period cycles=%0d found=%0d want 12",
                   cyc, found);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] v;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0)
        v = 12'($urandom);
      else
        v = {4'($urandom_range(0, 9)) & {4{1'($urandom)}},
             4'($urandom_range(0, 9)) & {4{1'($urandom)}},
             4'($urandom_range(0, 9))};
      bdc = v;
      repeat ($urandom_range(1, 20)) begin
        @(negedge clk);
        n_cmp++;
        if (disp_a !== m_disp || disp_b !== m_disp ||
            disp_c !== m_disp || an_a !== m_an ||
            an_b !== m_an || an_c !== m_an ||
            seg_a !== exp_seg(m_shown, m_dig, 1, 1) ||
            seg_b !== exp_seg(m_shown, m_dig, 0, 1) ||
            seg_c !== exp_seg(m_shown, m_dig, 1, 0)) begin
          n_bad++;
          $display("FAIL random disp=%h an=%b seg=%h/%h/%h want %h %b %h/%h/%h",
                   disp_a, an_a, seg_a, seg_b, seg_c,
                   m_disp, m_an,
                   exp_seg(m_shown, m_dig, 1, 1),
                   exp_seg(m_shown, m_dig, 0, 1),
                   exp_seg(m_shown, m_dig, 1, 0));
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bdc   = 12'h000;
    #12 rst = 1'b0;
    test_reset();
    test_hold_255();
    test_steps();
    test_blanking();
    test_period();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
